// File: rtl/trng_bus_pkg.sv
// trng_bus_pkg: shared constants and types for the TRNG register bus arbiter.
// Holds the TRNG register map, the common CTRL control words, the arbiter state
// enum and the maximum supported number of requesters.
package trng_bus_pkg;

    localparam int MAX_M = 4;

    localparam logic [31:0] ADDR_CTRL       = 32'h0000_0000;
    localparam logic [31:0] ADDR_XOR        = 32'h0000_0024;
    localparam logic [31:0] ADDR_STATE_CTRL = 32'h0000_0028;

    localparam logic [31:0] CTRL_IDLE  = 32'h0280_f700;
    localparam logic [31:0] CTRL_CFG   = 32'h0280_f70b;
    localparam logic [31:0] CTRL_RUN   = 32'h0280_f76b;
    localparam logic [31:0] CTRL_RD_EN = 32'h0280_f77b;

    typedef enum logic {
        ARB_UNLOCKED,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/trng_rr_pick.sv
// trng_rr_pick: combinational round-robin picker.
// Ports: req    - request vector
//        ptr    - highest-priority index this cycle
//        mask   - requests allowed to win (all ones when unrestricted)
//        gnt    - one-hot grant, zero when nothing eligible
//        idx    - index of the granted requester
//        any    - a grant was issued
module trng_rr_pick
    import trng_bus_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int IW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IW-1:0]    ptr,
    input  logic [NUM_M-1:0] mask,
    output logic [NUM_M-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [IW-1:0] c;

    // Scan from the farthest offset back to ptr so the nearest eligible
    // requester is the last one written and therefore wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            c = IW'((int'(ptr) + k) % NUM_M);
            if (req[c] && mask[c]) begin
                idx = c;
                gnt = NUM_M'(1) << c;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trng_bus_arbiter.sv
// trng_bus_arbiter: round-robin arbiter sharing the TRNG register slave port
// between NUM_M requesters, with locked multi-access sequences, a lock timeout
// and tagged read-data return.
// Ports: CLK_I/RESETN_I            - clock, asynchronous active-low reset
//        M_REQ_I/M_LOCK_I/M_WRITE_I - per-master request, lock, direction
//        M_ADDR_I/M_WDATA_I        - per-master payload, 32 bits each, packed
//        M_ACK_O                   - combinational accept (one-hot or zero)
//        M_RVALID_O/M_RDATA_O      - registered read return
//        LOCK_ERR_O                - one-cycle pulse on lock timeout
//        SEL_O/WRITE_O/ADDR_O/WDATA_O/RDATA_I - TRNG register slave port
module trng_bus_arbiter
    import trng_bus_pkg::*;
#(
    parameter int NUM_M      = 2,
    parameter int RD_LATENCY = 1,
    parameter int LOCK_TMO   = 255
) (
    input  logic                CLK_I,
    input  logic                RESETN_I,
    input  logic [NUM_M-1:0]    M_REQ_I,
    input  logic [NUM_M-1:0]    M_LOCK_I,
    input  logic [NUM_M-1:0]    M_WRITE_I,
    input  logic [NUM_M*32-1:0] M_ADDR_I,
    input  logic [NUM_M*32-1:0] M_WDATA_I,
    output logic [NUM_M-1:0]    M_ACK_O,
    output logic [NUM_M-1:0]    M_RVALID_O,
    output logic [31:0]         M_RDATA_O,
    output logic                LOCK_ERR_O,
    output logic                SEL_O,
    output logic                WRITE_O,
    output logic [31:0]         ADDR_O,
    output logic [31:0]         WDATA_O,
    input  logic [31:0]         RDATA_I
);

    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    arb_state_e                  state, state_d;
    logic [IW-1:0]               owner, owner_d, rr_ptr, rr_d, idx;
    logic [7:0]                  tmo_cnt, tmo_d;
    logic                        err_d, acc, any;
    logic [NUM_M-1:0]            gnt, mask;
    logic [RD_LATENCY:0]         tag_v;
    logic [RD_LATENCY:0][IW-1:0] tag_id;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return IW'((int'(i) + 1) % NUM_M);
    endfunction

    // While locked only the owner is eligible.
    assign mask = (state == ARB_LOCKED) ? NUM_M'(1) << owner : '1;

    trng_rr_pick #(
        .NUM_M(NUM_M),
        .IW   (IW)
    ) u_pick (
        .req (M_REQ_I),
        .ptr (rr_ptr),
        .mask(mask),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

    // Gated by reset so no master sees an accept while the bus is held in reset.
    assign acc     = any & RESETN_I;
    assign M_ACK_O = acc ? gnt : '0;

    // An owner accept takes priority over a timeout detected in the same cycle.
    always_comb begin
        state_d = state;
        owner_d = owner;
        rr_d    = rr_ptr;
        tmo_d   = tmo_cnt;
        err_d   = 1'b0;
        if (acc) begin
            state_d = M_LOCK_I[idx] ? ARB_LOCKED : ARB_UNLOCKED;
            owner_d = idx;
            rr_d    = wrap_inc(idx);
            tmo_d   = '0;
        end else if (state == ARB_LOCKED) begin
            if (tmo_cnt == 8'(LOCK_TMO)) begin
                state_d = ARB_UNLOCKED;
                rr_d    = wrap_inc(owner);
                tmo_d   = '0;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            state      <= ARB_UNLOCKED;
            owner      <= '0;
            rr_ptr     <= '0;
            tmo_cnt    <= '0;
            LOCK_ERR_O <= 1'b0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            rr_ptr     <= rr_d;
            tmo_cnt    <= tmo_d;
            LOCK_ERR_O <= err_d;
        end
    end

    // Slave strobe plus a tag shift register: stage RD_LATENCY lines up with
    // the cycle RDATA_I is valid for the read issued RD_LATENCY cycles earlier.
    always_ff @(posedge CLK_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            SEL_O      <= 1'b0;
            WRITE_O    <= 1'b0;
            ADDR_O     <= '0;
            WDATA_O    <= '0;
            tag_v      <= '0;
            tag_id     <= '0;
            M_RVALID_O <= '0;
            M_RDATA_O  <= '0;
        end else begin
            SEL_O      <= acc;
            tag_v      <= {tag_v[RD_LATENCY-1:0], acc & ~M_WRITE_I[idx]};
            tag_id     <= {tag_id[RD_LATENCY-1:0], idx};
            M_RVALID_O <= tag_v[RD_LATENCY] ? NUM_M'(1) << tag_id[RD_LATENCY] : '0;
            if (acc) begin
                WRITE_O <= M_WRITE_I[idx];
                ADDR_O  <= M_ADDR_I[32*idx +: 32];
                WDATA_O <= M_WDATA_I[32*idx +: 32];
            end
            if (tag_v[RD_LATENCY]) begin
                M_RDATA_O <= RDATA_I;
            end
        end
    end

endmodule

// File: doc/trng_bus_arbiter.md
# trng_bus_arbiter

Round-robin arbiter that shares the single TRNG register slave port (SEL/ADDR/WRITE/WDATA/RDATA) between NUM_M requesters, e.g. the TRNG sequencer and a host/debug master. It issues at most one register access per cycle and supports locked multi-access sequences (e.g. RD_EN write, XOR-data read, RUN write) that must not interleave with other masters. Read data is routed back to the issuing master by tag. It sits between the requesters and the TRNG register file.

## Interface
- NUM_M, 2: number of requesters (2..4).
- RD_LATENCY, 1: cycles from the SEL_O read cycle to the cycle RDATA_I is valid (1..3).
- LOCK_TMO, 255: idle cycles a lock owner may hold the bus before forced release (8-bit counter).
- CLK_I  in  1  clock.
- RESETN_I  in  1  reset, asynchronous, active-low.
- M_REQ_I  in  NUM_M  access request per master; held with payload until ACK.
- M_LOCK_I  in  NUM_M  keep ownership after this access.
- M_WRITE_I  in  NUM_M  1 = write, 0 = read.
- M_ADDR_I  in  NUM_M*32  address, master i at [32i+31:32i].
- M_WDATA_I  in  NUM_M*32  write data, same packing.
- M_ACK_O  out  NUM_M  combinational accept, one-hot or zero.
- M_RVALID_O  out  NUM_M  registered read-return pulse.
- M_RDATA_O  out  32  registered read data, shared, valid with M_RVALID_O.
- LOCK_ERR_O  out  1  one-cycle pulse on lock timeout.
- SEL_O, WRITE_O  out  1  registered slave strobe and direction.
- ADDR_O, WDATA_O  out  32  registered slave address and data.
- RDATA_I  in  32  slave read data.

## Operation
- Each cycle the arbiter accepts at most one request. M_ACK_O[i] = 1 means the access is taken at the next edge.
- State UNLOCKED: grant the first requesting master at or after rr_ptr, wrapping modulo NUM_M. On an accept of i with LOCK=1, move to LOCKED with owner = i. With LOCK=0, stay UNLOCKED. In both cases rr_ptr <= (i+1) mod NUM_M.
- State LOCKED: only the owner can be accepted. Other requests wait with ACK = 0.
  - An owner access with LOCK=0 returns to UNLOCKED.
  - An owner access with LOCK=1 stays LOCKED and clears tmo_cnt.
- Lock timeout:
  - tmo_cnt increments each LOCKED cycle with no owner accept.
  - When tmo_cnt reaches LOCK_TMO: return to UNLOCKED, pulse LOCK_ERR_O, and set rr_ptr to owner+1.
  - If an owner accept and the timeout fall in the same cycle, the accept wins and there is no error.
- Slave port:
  - On accept, SEL_O = 1 next cycle, with ADDR_O/WRITE_O/WDATA_O copied from the winner.
  - Otherwise SEL_O = 0 and ADDR_O/WDATA_O hold their last values.
  - WDATA_O is loaded on reads too; the slave ignores it.
- Read return:
  - A tag pipeline of depth RD_LATENCY+1 carries (valid, master id) of each read.
  - At the cycle RDATA_I is valid, M_RDATA_O <= RDATA_I and M_RVALID_O[id] <= 1 for one cycle.
  - Writes produce no return.
  - Back-to-back reads return in issue order, one per cycle.
- NUM_M = 1 degenerates to a pass-through plus a register stage; lock logic still applies.

## Timing
- Reset values: SEL_O = 0, WRITE_O = 0, ADDR_O = 0, WDATA_O = 0, M_RVALID_O = 0, M_RDATA_O = 0, LOCK_ERR_O = 0, state UNLOCKED, rr_ptr = 0, tmo_cnt = 0, tag pipeline cleared.
- Reset mid-operation drops outstanding reads; no RVALID is issued for them afterwards.
- Cycle t: REQ and ACK high for i.
- Cycle t+1: SEL_O high with i's payload.
- Cycle t+1+RD_LATENCY: RDATA_I sampled.
- Cycle t+2+RD_LATENCY: M_RVALID_O[i] and M_RDATA_O.
- Default read latency from ACK to RVALID: 3 cycles.
- Throughput: one access per cycle. A single master streaming back-to-back, unlocked, with no contention gets an ACK every cycle.
- LOCK_ERR_O asserts the cycle after tmo_cnt == LOCK_TMO is detected. The forced release takes effect in the same cycle, so another master may be ACKed that cycle.

## Structure
- Package trng_bus_pkg holds:
  - the TRNG register address constants (CTRL 0x00 … XOR 0x24, STATE_CTRL 0x28) and control words (0x0280f700/0b/6b/7b);
  - the arbiter state enum;
  - a MAX_M = 4 constant.
- Sub-module trng_rr_pick: combinational round-robin picker. Inputs req[NUM_M], ptr, and an optional mask. Outputs the one-hot grant and its index.

## Test plan
- Master 0 only, read 0x28 with RDATA_I = 0x4 at the slave: ACK at t, SEL_O/ADDR_O = 0x28 at t+1, M_RVALID_O[0] = 1 with M_RDATA_O = 0x4 at t+3.
- Masters 0 and 1 both requesting continuously, unlocked: grants alternate 0,1,0,1; SEL_O high every cycle.
- Master 0 performs a locked sequence (write 0x00 = 0x0280f77b with LOCK, read 0x24 with LOCK, write 0x00 = 0x0280f76b without LOCK) while master 1 requests: master 1 gets no ACK until the cycle after the third access, then is ACKed.
- Master 0 takes a lock and goes idle with LOCK_TMO = 8: LOCK_ERR_O pulses once after 8 idle cycles and master 1 is ACKed.
- Back-to-back reads from masters 0,1,0 with RD_LATENCY = 2: RVALID pulses on 0,1,0 in consecutive cycles carrying the matching RDATA_I values.
- Assert RESETN_I with two reads in flight: all outputs are 0 immediately, and no RVALID appears after release.
